// File: rtl/bbcbc_stream_gen.sv
// bbcbc_stream_gen: serial pattern transmitter for the BBCBC detection path.
// On an accepted start it sends PATTERN (bit 4 first) count_i times on d_o,
// qualified by valid_o, with gap_i idle cycles between repetitions.
//
// Optional feature macro: BBCBC_GEN_ERR_INJECT_EN
//   Adds err_i; when latched high, symbol index 0 of every repetition is
//   inverted so downstream detectors never see a clean pattern.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start_i  in   request pulse, honoured only while busy_o = 0
//   count_i  in   repetitions (CNT_W), latched on accepted start
//   gap_i    in   idle cycles between repetitions (GAP_W), latched on start
//   err_i    in   (macro only) corrupt last symbol of each repetition
//   d_o      out  serial symbol, 0 whenever valid_o = 0
//   valid_o  out  d_o qualifier
//   busy_o   out  high while sending or in an inter-pattern gap
//   done_o   out  one-cycle pulse after the final symbol
module bbcbc_stream_gen #(
  parameter logic [4:0]  PATTERN = 5'b11010,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
`ifdef BBCBC_GEN_ERR_INJECT_EN
  input  logic             err_i,
`endif
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IDX_W   = 3;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic [CNT_W-1:0] r_rem, w_rem_nx, w_rem_dec;
  logic [GAP_W-1:0] r_gap_len, w_gap_len_nx;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nx;
  logic             r_d, r_valid, r_busy, r_done;
  logic             w_d_nx, w_valid_nx, w_busy_nx, w_done_nx;
  logic             w_inj;

`ifdef BBCBC_GEN_ERR_INJECT_EN
  logic r_err, w_err_nx;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_rem     <= '0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
      r_d       <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef BBCBC_GEN_ERR_INJECT_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_rem     <= w_rem_nx;
      r_gap_len <= w_gap_len_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_d       <= w_d_nx;
      r_valid   <= w_valid_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
`ifdef BBCBC_GEN_ERR_INJECT_EN
      r_err     <= w_err_nx;
`endif
    end
  end

  // Next state; outputs are derived from the next state so they line up
  // with it once registered (symbol 4 appears the cycle after the start edge)
  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_rem_nx     = r_rem;
    w_gap_len_nx = r_gap_len;
    w_gap_cnt_nx = r_gap_cnt;
    w_rem_dec    = r_rem - CNT_W'(1);
`ifdef BBCBC_GEN_ERR_INJECT_EN
    w_err_nx     = r_err;
`endif

    case (r_state)
      // DONE samples start_i exactly like IDLE so requests can chain
      S_IDLE, S_DONE: begin
        w_state_nx = S_IDLE;
        if (start_i) begin
          if (count_i != '0) begin
            w_state_nx   = S_SEND;
            w_idx_nx     = IDX_FIRST;
            w_rem_nx     = count_i;
            w_gap_len_nx = gap_i;
            w_gap_cnt_nx = '0;
`ifdef BBCBC_GEN_ERR_INJECT_EN
            w_err_nx     = err_i;
`endif
          end else begin
            w_state_nx = S_DONE;
          end
        end
      end

      S_SEND: begin
        if (r_idx == '0) begin
          w_rem_nx = w_rem_dec;
          if (w_rem_dec == '0) begin
            w_state_nx = S_DONE;
          end else if (r_gap_len == '0) begin
            w_idx_nx = IDX_FIRST;
          end else begin
            // Counter runs gap_len-1 down to 0: exactly gap_len idle cycles
            w_state_nx   = S_GAP;
            w_gap_cnt_nx = r_gap_len - GAP_W'(1);
          end
        end else begin
          w_idx_nx = r_idx - IDX_W'(1);
        end
      end

      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nx = S_SEND;
          w_idx_nx   = IDX_FIRST;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        w_state_nx   = S_IDLE;
        w_idx_nx     = '0;
        w_rem_nx     = '0;
        w_gap_len_nx = '0;
        w_gap_cnt_nx = '0;
`ifdef BBCBC_GEN_ERR_INJECT_EN
        w_err_nx     = 1'b0;
`endif
      end
    endcase

`ifdef BBCBC_GEN_ERR_INJECT_EN
    w_inj = w_err_nx && (w_idx_nx == '0);
`else
    w_inj = 1'b0;
`endif

    w_valid_nx = (w_state_nx == S_SEND);
    w_d_nx     = w_valid_nx ? (PATTERN[w_idx_nx] ^ w_inj) : 1'b0;
    w_busy_nx  = (w_state_nx == S_SEND) || (w_state_nx == S_GAP);
    w_done_nx  = (w_state_nx == S_DONE);
  end

  assign d_o     = r_d;
  assign valid_o = r_valid;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_bbcbc_stream_gen.sv
module tb_bbcbc_stream_gen;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;
`ifdef BBCBC_GEN_ERR_INJECT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [CNT_W-1:0] count_i;
  logic [GAP_W-1:0] gap_i;
  logic             err_i;
  logic             d_o, valid_o, busy_o, done_o;

  always #5 clk = ~clk;

  bbcbc_stream_gen #(.PATTERN(5'b11010), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .count_i (count_i),
    .gap_i   (gap_i),
`ifdef BBCBC_GEN_ERR_INJECT_EN
    .err_i   (err_i),
`endif
    .d_o     (d_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  typedef struct packed {
    logic v;
    logic d;
    logic b;
    logic dn;
  } cyc_t;

  localparam cyc_t IDLE_C = '{v: 1'b0, d: 1'b0, b: 1'b0, dn: 1'b0};

  cyc_t       exp_q[$];
  cyc_t       cur;
  logic [4:0] pat = 5'b11010;
  logic [4:0] hist;
  int         hits;
  int         checks;
  int         errors;

  // Expected per-cycle output list of one accepted request
  task automatic push_xfer(input int c, input int g, input bit e);
    bit sym;
    if (c == 0) begin
      exp_q.push_back('{v: 1'b0, d: 1'b0, b: 1'b0, dn: 1'b1});
    end else begin
      for (int r = 0; r < c; r++) begin
        for (int k = 0; k < 5; k++) begin
          sym = pat[4-k];
          if (e && ERR_ON && k == 4) sym = ~sym;
          exp_q.push_back('{v: 1'b1, d: sym, b: 1'b1, dn: 1'b0});
        end
        if (r < c - 1)
          for (int j = 0; j < g; j++)
            exp_q.push_back('{v: 1'b0, d: 1'b0, b: 1'b1, dn: 1'b0});
      end
      exp_q.push_back('{v: 1'b0, d: 1'b0, b: 1'b0, dn: 1'b1});
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sample_and_check();
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_C;
    check("valid_o", valid_o, cur.v);
    check("d_o",     d_o,     cur.d);
    check("busy_o",  busy_o,  cur.b);
    check("done_o",  done_o,  cur.dn);
    if (valid_o === 1'b1) begin
      hist = {hist[3:0], d_o};
      if (hist == 5'b11010) hits++;
    end
  endtask

  // One clock: apply inputs for the coming edge, then check the cycle after it
  task automatic step(input bit s, input int c, input int g, input bit e);
    start_i = s;
    count_i = CNT_W'(c);
    gap_i   = GAP_W'(g);
    err_i   = e;
    if (s && !cur.b) push_xfer(c, g, e);
    @(negedge clk);
    sample_and_check();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    cur  = IDLE_C;
    hist = '0;
    check("rst_valid", valid_o, 1'b0);
    check("rst_d",     d_o,     1'b0);
    check("rst_busy",  busy_o,  1'b0);
    check("rst_done",  done_o,  1'b0);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end
    check("drain_timeout", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    int h0;
    checks  = 0;
    errors  = 0;
    hits    = 0;
    hist    = '0;
    cur     = IDLE_C;
    rst     = 1'b1;
    start_i = 1'b0;
    count_i = '0;
    gap_i   = '0;
    err_i   = 1'b0;
    @(negedge clk);
    do_reset();

    // Quiet after reset
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b0);

    // Zero-count request: done only, no symbols
    step(1'b1, 0, 5, 1'b0);
    check("cnt0_done", done_o, 1'b1);
    drain(10);
    step(1'b0, 0, 0, 1'b0);

    // Single pattern
    step(1'b1, 1, 0, 1'b0);
    drain(20);
    step(1'b0, 0, 0, 1'b0);

    // Three repetitions with 2-cycle gap; detector sees three patterns
    h0 = hits;
    step(1'b1, 3, 2, 1'b0);
    drain(40);
    check("det_hits_3", (hits - h0) == 3, 1'b1);
    step(1'b0, 0, 0, 1'b0);

    // Back-to-back reps; start at symbol 3 ignored; start during done accepted
    step(1'b1, 2, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 7, 3, 1'b0);
    while (!cur.dn && exp_q.size() > 0) step(1'b0, 0, 0, 1'b0);
    step(1'b1, 1, 3, 1'b0);
    check("chain_first_sym", valid_o, 1'b1);
    drain(20);
    step(1'b0, 0, 0, 1'b0);

    // Reset on 2nd symbol of repetition 2 of 4: abandoned, no done
    step(1'b1, 4, 1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 0, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);
    step(1'b1, 1, 0, 1'b0);
    drain(20);

    // Full-range repetition count, no wrap
    step(1'b1, 255, 0, 1'b0);
    drain(1400);

    // Error injection: patterns corrupted, detector stays silent
    h0 = hits;
    step(1'b1, 2, 1, 1'b1);
    drain(30);
    check("det_err_hits", (hits - h0) == (ERR_ON ? 0 : 2), 1'b1);

    // Randomised transfers with random stray start pulses
    for (int t = 0; t < 20; t++) begin
      step(1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
      for (int n = 0; n < 200 && exp_q.size() > 0; n++)
        step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drain(200);
      step(1'b0, 0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
